// File: rtl/jtdd_dwnld_remap.sv
// jtdd_dwnld_remap
// Converts the loader byte stream into SDRAM write requests and priority-PROM
// write strobes. Linear regions map a byte address straight onto a 16-bit word
// address and byte lane. The scroll and object regions are folded so that the
// upper half of each region lands on the upper byte lane.
//
// Ports
//   clk, rst_n                       clock, asynchronous active-low reset
//   downloading                      download in progress; bytes ignored when low
//   ioctl_addr/ioctl_data/ioctl_wr   incoming byte stream (one-cycle strobe)
//   prog_addr/prog_data/prog_mask    SDRAM word address, byte, active-low lane enable
//   prog_we, sdram_ack               SDRAM request / acceptance handshake
//   prom_we                          one-cycle priority-PROM strobe (addr[7:0], data[3:0])
//   overflow                         sticky: a byte was lost because pending was full
//   dwnld_done                       one-cycle pulse once the download has drained
//   checksum                         16-bit byte sum of accepted bytes
//
// Build option
//   JTDD_DWNLD_CHECKSUM_EN  enables the checksum adder; otherwise checksum is 0.
//
// state | meaning
// IDLE  | nothing in flight
// REQ   | SDRAM write presented, waiting for sdram_ack
// PROM  | prom_we asserted for this single cycle
module jtdd_dwnld_remap #(
  parameter logic [21:0] SCR_START  = 22'h6_0000,
  parameter logic [21:0] OBJ_START  = 22'h8_0000,
  parameter logic [21:0] MCU_START  = 22'hC_0000,
  parameter logic [21:0] PROM_START = 22'hC_4000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        downloading,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_data,
  input  logic        ioctl_wr,
  output logic [21:0] prog_addr,
  output logic [7:0]  prog_data,
  output logic [1:0]  prog_mask,
  output logic        prog_we,
  input  logic        sdram_ack,
  output logic        prom_we,
  output logic        overflow,
  output logic        dwnld_done,
  output logic [15:0] checksum
);

  typedef enum logic [1:0] {IDLE, REQ, PROM} state_t;

  state_t      state, state_nxt;
  logic        pend_valid, pend_nxt;
  logic [24:0] pend_addr, pend_addr_nxt;
  logic [7:0]  pend_data, pend_data_nxt;
  logic        armed;

  logic        new_ok, new_wr, retire, launch, ovf_set;
  logic [24:0] src_addr;
  logic [7:0]  src_data;
  logic [16:0] off_scr;
  logic [17:0] off_obj;
  logic        off_mcu0;
  logic [7:0]  off_prom;
  logic        map_prom;
  logic [21:0] map_addr;
  logic [1:0]  map_mask;

  // Bytes past the 256-byte PROM window are discarded outright.
  assign new_ok = ioctl_addr < ({3'b000, PROM_START} + 25'd256);
  assign new_wr = ioctl_wr & downloading & new_ok;

  // A pending byte always goes out before a freshly arriving one.
  assign src_addr = pend_valid ? pend_addr : ioctl_addr;
  assign src_data = pend_valid ? pend_data : ioctl_data;

  // Only the low bits of each region offset matter, so subtract narrow.
  assign off_scr  = src_addr[16:0] - SCR_START[16:0];
  assign off_obj  = src_addr[17:0] - OBJ_START[17:0];
  assign off_mcu0 = src_addr[0] ^ MCU_START[0];
  assign off_prom = src_addr[7:0] - PROM_START[7:0];

  always_comb begin
    map_prom = 1'b0;
    map_addr = 22'd0;
    map_mask = 2'b11;
    if (src_addr < {3'b000, SCR_START}) begin
      map_addr = src_addr[22:1];
      map_mask = src_addr[0] ? 2'b01 : 2'b10;
    end else if (src_addr < {3'b000, OBJ_START}) begin
      map_addr = (SCR_START >> 1) + {6'd0, off_scr[15:0]};
      map_mask = off_scr[16] ? 2'b01 : 2'b10;
    end else if (src_addr < {3'b000, MCU_START}) begin
      map_addr = (OBJ_START >> 1) + {5'd0, off_obj[16:0]};
      map_mask = off_obj[17] ? 2'b01 : 2'b10;
    end else if (src_addr < {3'b000, PROM_START}) begin
      map_addr = src_addr[22:1];
      map_mask = off_mcu0 ? 2'b01 : 2'b10;
    end else begin
      map_prom = 1'b1;
      map_addr = {14'd0, off_prom};
    end
  end

  // PROM lasts exactly one cycle, so it retires unconditionally.
  assign retire = (state == PROM) || (state == REQ && sdram_ack);

  always_comb begin
    state_nxt     = state;
    pend_nxt      = pend_valid;
    pend_addr_nxt = pend_addr;
    pend_data_nxt = pend_data;
    launch        = 1'b0;
    ovf_set       = 1'b0;
    if (state == IDLE) begin
      launch = new_wr;
    end else if (retire) begin
      if (pend_valid) begin
        launch   = 1'b1;
        pend_nxt = new_wr;
        if (new_wr) begin
          pend_addr_nxt = ioctl_addr;
          pend_data_nxt = ioctl_data;
        end
      end else if (new_wr) begin
        launch = 1'b1;
      end else begin
        state_nxt = IDLE;
      end
    end else if (new_wr) begin
      if (pend_valid) begin
        ovf_set = 1'b1;
      end else begin
        pend_nxt      = 1'b1;
        pend_addr_nxt = ioctl_addr;
        pend_data_nxt = ioctl_data;
      end
    end
    if (launch) state_nxt = map_prom ? PROM : REQ;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      pend_valid <= 1'b0;
      pend_addr  <= 25'd0;
      pend_data  <= 8'd0;
      prog_addr  <= 22'd0;
      prog_data  <= 8'd0;
      prog_mask  <= 2'b11;
      overflow   <= 1'b0;
      armed      <= 1'b0;
    end else begin
      state      <= state_nxt;
      pend_valid <= pend_nxt;
      pend_addr  <= pend_addr_nxt;
      pend_data  <= pend_data_nxt;
      if (launch) begin
        prog_addr <= map_addr;
        prog_data <= src_data;
        prog_mask <= map_mask;
      end
      if (ovf_set) overflow <= 1'b1;
      if (downloading)     armed <= 1'b1;
      else if (dwnld_done) armed <= 1'b0;
    end
  end

  // Strobes come straight from the state register so reset kills them at once.
  assign prog_we    = (state == REQ);
  assign prom_we    = (state == PROM);
  assign dwnld_done = armed & ~downloading & (state == IDLE) & ~pend_valid;

`ifdef JTDD_DWNLD_CHECKSUM_EN
  logic take;
  assign take = new_wr & ~ovf_set;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    checksum <= 16'h0000;
    else if (take) checksum <= checksum + {8'h00, ioctl_data};
  end
`else
  assign checksum = 16'h0000;
`endif

endmodule

// File: tb/tb_jtdd_dwnld_remap.sv
// Directed bench for jtdd_dwnld_remap: a table of single-byte transactions
// followed by hand-written multi-cycle sequences.
module tb_jtdd_dwnld_remap;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        downloading;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_data;
  logic        ioctl_wr;
  logic [21:0] prog_addr;
  logic [7:0]  prog_data;
  logic [1:0]  prog_mask;
  logic        prog_we;
  logic        sdram_ack;
  logic        prom_we;
  logic        overflow;
  logic        dwnld_done;
  logic [15:0] checksum;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  jtdd_dwnld_remap dut (
    .clk(clk), .rst_n(rst_n), .downloading(downloading),
    .ioctl_addr(ioctl_addr), .ioctl_data(ioctl_data), .ioctl_wr(ioctl_wr),
    .prog_addr(prog_addr), .prog_data(prog_data), .prog_mask(prog_mask),
    .prog_we(prog_we), .sdram_ack(sdram_ack), .prom_we(prom_we),
    .overflow(overflow), .dwnld_done(dwnld_done), .checksum(checksum)
  );

  localparam logic [1:0] K_SD = 2'd0, K_PROM = 2'd1, K_IGN = 2'd2;

  typedef struct {
    logic [24:0] a;
    logic [7:0]  d;
    logic [1:0]  kind;
    logic [21:0] ea;
    logic [1:0]  em;
  } vec_t;

  vec_t tbl[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Present one byte for one cycle; returns at the negedge after capture.
  task automatic send(input logic [24:0] a, input logic [7:0] d);
    @(negedge clk);
    ioctl_addr = a;
    ioctl_data = d;
    ioctl_wr   = 1'b1;
    @(negedge clk);
    ioctl_wr   = 1'b0;
  endtask

  task automatic ack_one();
    sdram_ack = 1'b1;
    @(negedge clk);
    sdram_ack = 1'b0;
  endtask

  logic [15:0] exp_sum;

  initial begin
    rst_n = 1'b0; downloading = 1'b0; ioctl_addr = '0; ioctl_data = '0;
    ioctl_wr = 1'b0; sdram_ack = 1'b0;

    tbl[0]  = '{25'h0_0003, 8'h12, K_SD,   22'h0_0001, 2'b01};
    tbl[1]  = '{25'h0_0004, 8'h34, K_SD,   22'h0_0002, 2'b10};
    tbl[2]  = '{25'h5_FFFF, 8'h56, K_SD,   22'h2_FFFF, 2'b01};
    tbl[3]  = '{25'h6_0000, 8'h78, K_SD,   22'h3_0000, 2'b10};
    tbl[4]  = '{25'h7_0005, 8'h9A, K_SD,   22'h3_0005, 2'b01};
    tbl[5]  = '{25'h6_FFFF, 8'hBC, K_SD,   22'h3_FFFF, 2'b10};
    tbl[6]  = '{25'h8_0000, 8'hDE, K_SD,   22'h4_0000, 2'b10};
    tbl[7]  = '{25'hA_0001, 8'hF0, K_SD,   22'h4_0001, 2'b01};
    tbl[8]  = '{25'hB_FFFF, 8'h11, K_SD,   22'h5_FFFF, 2'b01};
    tbl[9]  = '{25'hC_0000, 8'h22, K_SD,   22'h6_0000, 2'b10};
    tbl[10] = '{25'hC_3FFF, 8'h33, K_SD,   22'h6_1FFF, 2'b01};
    tbl[11] = '{25'hC_4010, 8'h0A, K_PROM, 22'h0_0010, 2'b11};
    tbl[12] = '{25'hC_40FF, 8'h05, K_PROM, 22'h0_00FF, 2'b11};
    tbl[13] = '{25'hC_4100, 8'h07, K_IGN,  22'h0_0000, 2'b11};

    // Reset values, sampled while reset is held.
    repeat (2) @(negedge clk);
    chk("rst prog_we",   {31'd0, prog_we},    32'd0);
    chk("rst prom_we",   {31'd0, prom_we},    32'd0);
    chk("rst prog_addr", {10'd0, prog_addr},  32'd0);
    chk("rst prog_data", {24'd0, prog_data},  32'd0);
    chk("rst prog_mask", {30'd0, prog_mask},  32'd3);
    chk("rst overflow",  {31'd0, overflow},   32'd0);
    chk("rst done",      {31'd0, dwnld_done}, 32'd0);
    chk("rst checksum",  {16'd0, checksum},   32'd0);
    rst_n = 1'b1;
    downloading = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 14; i++) begin
      send(tbl[i].a, tbl[i].d);
      case (tbl[i].kind)
        K_SD: begin
          chk($sformatf("v%0d prog_we", i), {31'd0, prog_we}, 32'd1);
          chk($sformatf("v%0d prom_we", i), {31'd0, prom_we}, 32'd0);
          chk($sformatf("v%0d addr", i), {10'd0, prog_addr}, {10'd0, tbl[i].ea});
          chk($sformatf("v%0d mask", i), {30'd0, prog_mask}, {30'd0, tbl[i].em});
          chk($sformatf("v%0d data", i), {24'd0, prog_data}, {24'd0, tbl[i].d});
          repeat (2) @(negedge clk);
          chk($sformatf("v%0d hold we", i), {31'd0, prog_we}, 32'd1);
          chk($sformatf("v%0d hold addr", i), {10'd0, prog_addr}, {10'd0, tbl[i].ea});
          ack_one();
          chk($sformatf("v%0d we after ack", i), {31'd0, prog_we}, 32'd0);
        end
        K_PROM: begin
          chk($sformatf("v%0d prom_we", i), {31'd0, prom_we}, 32'd1);
          chk($sformatf("v%0d prog_we", i), {31'd0, prog_we}, 32'd0);
          chk($sformatf("v%0d prom addr", i), {24'd0, prog_addr[7:0]}, {24'd0, tbl[i].ea[7:0]});
          chk($sformatf("v%0d prom data", i), {28'd0, prog_data[3:0]}, {28'd0, tbl[i].d[3:0]});
          @(negedge clk);
          chk($sformatf("v%0d prom_we off", i), {31'd0, prom_we}, 32'd0);
        end
        default: begin
          chk($sformatf("v%0d ign prog_we", i), {31'd0, prog_we}, 32'd0);
          chk($sformatf("v%0d ign prom_we", i), {31'd0, prom_we}, 32'd0);
        end
      endcase
    end

    // Checksum of 0xFF + 0x02.
    do_reset();
    send(25'h10, 8'hFF);
    ack_one();
    send(25'h11, 8'h02);
    ack_one();
`ifdef JTDD_DWNLD_CHECKSUM_EN
    exp_sum = 16'h0101;
`else
    exp_sum = 16'h0000;
`endif
    chk("checksum", {16'd0, checksum}, {16'd0, exp_sum});

    // Three back-to-back bytes with ack withheld: second pends, third is lost.
    do_reset();
    @(negedge clk);
    ioctl_wr = 1'b1; ioctl_addr = 25'h100; ioctl_data = 8'hA1;
    @(negedge clk);
    ioctl_addr = 25'h101; ioctl_data = 8'hA2;
    @(negedge clk);
    ioctl_addr = 25'h102; ioctl_data = 8'hA3;
    @(negedge clk);
    ioctl_wr = 1'b0;
    chk("ovf flag", {31'd0, overflow}, 32'd1);
    repeat (10) @(negedge clk);
    chk("ovf b1 we",   {31'd0, prog_we},   32'd1);
    chk("ovf b1 addr", {10'd0, prog_addr}, 32'h80);
    chk("ovf b1 data", {24'd0, prog_data}, 32'hA1);
    ack_one();
    chk("ovf b2 we",   {31'd0, prog_we},   32'd1);
    chk("ovf b2 addr", {10'd0, prog_addr}, 32'h80);
    chk("ovf b2 mask", {30'd0, prog_mask}, 32'd1);
    chk("ovf b2 data", {24'd0, prog_data}, 32'hA2);
    ack_one();
    chk("ovf drained", {31'd0, prog_we}, 32'd0);
    chk("ovf sticky",  {31'd0, overflow}, 32'd1);

    // New byte coinciding with ack: current retires, new one goes out next.
    do_reset();
    send(25'h200, 8'h66);
    ioctl_wr = 1'b1; ioctl_addr = 25'h205; ioctl_data = 8'h77; sdram_ack = 1'b1;
    @(negedge clk);
    ioctl_wr = 1'b0; sdram_ack = 1'b0;
    chk("coin we",   {31'd0, prog_we},   32'd1);
    chk("coin addr", {10'd0, prog_addr}, 32'h102);
    chk("coin mask", {30'd0, prog_mask}, 32'd1);
    chk("coin data", {24'd0, prog_data}, 32'h77);
    chk("coin ovf",  {31'd0, overflow},  32'd0);
    ack_one();
    chk("coin done we", {31'd0, prog_we}, 32'd0);

    // Byte arriving during the PROM cycle goes straight to REQ.
    send(25'hC_4020, 8'h03);
    chk("pp prom_we", {31'd0, prom_we}, 32'd1);
    ioctl_wr = 1'b1; ioctl_addr = 25'h300; ioctl_data = 8'h44;
    @(negedge clk);
    ioctl_wr = 1'b0;
    chk("pp prog_we", {31'd0, prog_we},   32'd1);
    chk("pp prom off",{31'd0, prom_we},   32'd0);
    chk("pp addr",    {10'd0, prog_addr}, 32'h180);
    chk("pp mask",    {30'd0, prog_mask}, 32'd2);
    ack_one();

    // downloading falls while a request waits; done pulses after the ack.
    send(25'h400, 8'h55);
    downloading = 1'b0;
    @(negedge clk);
    chk("done held", {31'd0, dwnld_done}, 32'd0);
    @(negedge clk);
    chk("done held2", {31'd0, dwnld_done}, 32'd0);
    ack_one();
    chk("done pulse", {31'd0, dwnld_done}, 32'd1);
    @(negedge clk);
    chk("done once", {31'd0, dwnld_done}, 32'd0);

    // Writes are ignored while not downloading.
    send(25'h500, 8'h99);
    chk("nodl we", {31'd0, prog_we}, 32'd0);

    // Reset in the middle of a request drops prog_we immediately.
    downloading = 1'b1;
    send(25'h600, 8'h88);
    chk("mid we", {31'd0, prog_we}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid rst we", {31'd0, prog_we}, 32'd0);
    chk("mid rst addr", {10'd0, prog_addr}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
